// File: rtl/lut_multiplier_seq.sv
// ---------------------------------------------------------------------------
// lut_multiplier_seq
//
// Iterative unsigned multiplier built around a small table of multiples of A.
// Once an operand pair is accepted, the block fills a table with 0*A, 1*A, ...
// (2^DIGIT_W-1)*A, writing one entry per cycle. It then walks B one DIGIT_W-bit
// digit per cycle, least significant digit first. On each step it adds the
// selected table entry, shifted to that digit's weight, into the accumulator.
// Both sides use valid/ready handshakes. The block holds only one operation
// at a time.
//
// Parameters
//   A_W        width of multiplicand A
//   B_W        width of multiplier B (a multiple of DIGIT_W)
//   DIGIT_W    bits of B consumed per accumulate cycle (1..6)
//   EARLY_EXIT 1: stop once the remaining B digits are all zero; 0: fixed latency
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous reset, active HIGH despite the name
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   src_a      multiplicand
//   src_b      multiplier
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   result     full-width product, registered, held until the next DONE or reset
//   busy       high while building the table or accumulating
// ---------------------------------------------------------------------------
module lut_multiplier_seq #(
    parameter int A_W        = 32,
    parameter int B_W        = 32,
    parameter int DIGIT_W    = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       src_a,
    input  logic [B_W-1:0]       src_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   result,
    output logic                 busy
);

    localparam int NDIG  = B_W / DIGIT_W;
    localparam int LUT_D = 1 << DIGIT_W;
    localparam int E_W   = A_W + DIGIT_W;
    localparam int P_W   = A_W + B_W;
    localparam int I_W   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Reject illegal configurations at elaboration time.
    if (DIGIT_W < 1 || DIGIT_W > 6) begin : g_bad_digit_w
        $error("lut_multiplier_seq: DIGIT_W must be in 1..6");
    end
    if ((B_W % DIGIT_W) != 0) begin : g_bad_b_w
        $error("lut_multiplier_seq: B_W must be a multiple of DIGIT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_ACC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [A_W-1:0]       a_reg;
    logic [B_W-1:0]       b_rem;          // B shifted right as digits are consumed
    logic [E_W-1:0]       lut [LUT_D];
    logic [P_W-1:0]       acc;
    logic [P_W-1:0]       result_reg;
    logic [DIGIT_W-1:0]   k;              // next table entry to write
    logic [I_W-1:0]       i;              // current digit index

    logic [DIGIT_W-1:0]   digit;
    logic [B_W-1:0]       b_upper;
    logic [P_W-1:0]       term;
    logic [P_W-1:0]       acc_sum;
    logic                 last_digit;
    logic                 build_last;

    // Datapath for the accumulate step. Because the product fits in P_W bits,
    // shifting the table entry left never drops a significant bit.
    assign digit      = b_rem[DIGIT_W-1:0];
    assign b_upper    = b_rem >> DIGIT_W;
    assign term       = P_W'(lut[digit]) << (int'(i) * DIGIT_W);
    assign acc_sum    = acc + term;
    assign build_last = &k;
    assign last_digit = (i == I_W'(NDIG - 1)) ||
                        ((EARLY_EXIT != 0) && (b_upper == '0));

    assign result = result_reg;

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_BUILD;
                end
            end
            S_BUILD: begin
                busy = 1'b1;
                if (build_last) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state      <= S_IDLE;
            a_reg      <= '0;
            b_rem      <= '0;
            acc        <= '0;
            result_reg <= '0;
            k          <= '0;
            i          <= '0;
            for (int n = 0; n < LUT_D; n++) begin
                lut[n] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg  <= src_a;
                        b_rem  <= src_b;
                        lut[0] <= '0;
                        acc    <= '0;
                        k      <= DIGIT_W'(1);
                        i      <= '0;
                    end
                end
                S_BUILD: begin
                    // Each entry is the previous one plus A, so no multiplier is needed.
                    lut[k] <= lut[k - DIGIT_W'(1)] + E_W'(a_reg);
                    k      <= k + DIGIT_W'(1);
                    i      <= '0;
                end
                S_ACC: begin
                    acc   <= acc_sum;
                    b_rem <= b_upper;
                    i     <= i + I_W'(1);
                    if (last_digit) begin
                        result_reg <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_lut_multiplier_seq
//
// Bench for lut_multiplier_seq. It builds four instances that share the clock,
// the reset and the operand buses:
//   unit 0: default parameters (DIGIT_W=4, EARLY_EXIT=1)
//   unit 1: DIGIT_W=4, EARLY_EXIT=0
//   unit 2: DIGIT_W=1, EARLY_EXIT=0
//   unit 3: DIGIT_W=2, EARLY_EXIT=0
// A table of directed vectors holds the expected product and the expected
// accept-to-out_valid latency for each case. Separate hand-written sequences
// cover the result stall and the reset abort.
// ---------------------------------------------------------------------------
module tb_lut_multiplier_seq;

    logic        clk;
    logic        resetn;
    logic        out_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  in_valid_v;
    logic [3:0]  in_ready_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  busy_v;
    logic [63:0] result_v [4];

    int n_cmp;
    int n_fail;

    lut_multiplier_seq dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .result(result_v[0]), .busy(busy_v[0])
    );

    lut_multiplier_seq #(.A_W(32), .B_W(32), .DIGIT_W(4), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .result(result_v[1]), .busy(busy_v[1])
    );

    lut_multiplier_seq #(.A_W(32), .B_W(32), .DIGIT_W(1), .EARLY_EXIT(0)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .result(result_v[2]), .busy(busy_v[2])
    );

    lut_multiplier_seq #(.A_W(32), .B_W(32), .DIGIT_W(2), .EARLY_EXIT(0)) dut3 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid_v[3]), .out_ready(out_ready),
        .result(result_v[3]), .busy(busy_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          unit;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one full operation on unit u. It checks the accept, the latency,
    // the result, the one-cycle out_valid pulse and the return of in_ready.
    task automatic do_op(input int u, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat);
        int cnt;
        bit seen;
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready_v[u]), 64'd1);
        src_a         = a;
        src_b         = b;
        in_valid_v[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[u] = 1'b0;
        // The operands are latched at accept, so scrambling the buses must not matter.
        src_a = ~a;
        src_b = ~b;
        chk("busy_after_accept", 64'(busy_v[u]), 64'd1);
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 200 && !seen) begin
            @(posedge clk);
            #1;
            cnt++;
            seen = out_valid_v[u];
        end
        chk("out_valid_seen", 64'(seen), 64'd1);
        chk("latency", 64'(cnt), 64'(lat));
        chk("result", result_v[u], exp);
        chk("in_ready_low_in_done", 64'(in_ready_v[u]), 64'd0);
        @(posedge clk);
        #1;
        chk("out_valid_one_cycle", 64'(out_valid_v[u]), 64'd0);
        chk("in_ready_back", 64'(in_ready_v[u]), 64'd1);
        chk("result_held_in_idle", result_v[u], exp);
        $display("op unit=%0d a=0x%08h b=0x%08h result=0x%016h latency=%0d", u, a, b, result_v[u], cnt);
    endtask

    initial begin
        int cnt;
        int pulses;
        bit seen;

        n_cmp      = 0;
        n_fail     = 0;
        resetn     = 1'b1;
        out_ready  = 1'b1;
        in_valid_v = '0;
        src_a      = '0;
        src_b      = '0;

        vecs[0]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 23};
        vecs[1]  = '{0, 32'd7,        32'd3,        64'd21,               16};
        vecs[2]  = '{1, 32'd7,        32'd3,        64'd21,               23};
        vecs[3]  = '{0, 32'h12345678, 32'h0,        64'd0,                16};
        vecs[4]  = '{0, 32'h0,        32'h80000000, 64'd0,                23};
        vecs[5]  = '{2, 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 33};
        vecs[6]  = '{3, 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 19};
        vecs[7]  = '{0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 20};
        vecs[8]  = '{1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 23};
        vecs[9]  = '{2, 32'd3,        32'd5,        64'd15,               33};
        vecs[10] = '{0, 32'd100,      32'd200,      64'd20000,            17};
        vecs[11] = '{3, 32'hFFFFFFFF, 32'd2,        64'h00000001FFFFFFFE, 19};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready_v), 64'hF);
        chk("reset_out_valid", 64'(out_valid_v), 64'h0);
        chk("reset_busy", 64'(busy_v), 64'h0);
        chk("reset_result", result_v[0], 64'd0);
        @(negedge clk);
        resetn = 1'b0;

        // Directed vectors
        for (int v = 0; v < 12; v++) begin
            do_op(vecs[v].unit, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].lat);
        end

        // Result stall: out_ready low for 10 cycles while new operands are offered
        @(negedge clk);
        out_ready     = 1'b0;
        src_a         = 32'd6;
        src_b         = 32'd7;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 200 && !seen) begin
            @(posedge clk);
            #1;
            cnt++;
            seen = out_valid_v[0];
        end
        chk("stall_out_valid_seen", 64'(seen), 64'd1);
        chk("stall_latency", 64'(cnt), 64'd16);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1;
            src_a         = $urandom;
            src_b         = $urandom;
            @(posedge clk);
            #1;
            chk("stall_out_valid", 64'(out_valid_v[0]), 64'd1);
            chk("stall_result", result_v[0], 64'd42);
            chk("stall_in_ready", 64'(in_ready_v[0]), 64'd0);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        out_ready     = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("stall_release_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("stall_release_result", result_v[0], 64'd42);
        $display("op unit=0 a=0x00000006 b=0x00000007 stalled 10 cycles result=0x%016h", result_v[0]);
        do_op(0, 32'd9, 32'd9, 64'd81, 16);

        // Reset in the third ACC cycle aborts the operation
        @(negedge clk);
        src_a         = 32'hFFFFFFFF;
        src_b         = 32'hFFFFFFFF;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        chk("abort_busy_before_reset", 64'(busy_v[0]), 64'd1);
        resetn = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("abort_busy", 64'(busy_v[0]), 64'd0);
        chk("abort_result", result_v[0], 64'd0);
        @(negedge clk);
        resetn = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_v[0]) pulses++;
        end
        chk("abort_no_out_valid", 64'(pulses), 64'd0);
        $display("op unit=0 a=0xffffffff b=0xffffffff aborted by reset");
        do_op(0, 32'd100, 32'd200, 64'd20000, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_multiplier_seq.md
Name: lut_multiplier_seq

Overview:
Parametrised, iterative LUT-based unsigned multiplier and the sequential successor of the combinational 2b/4b LUT multiplier tree. On accepting an operand pair it builds a table of all multiples 0..(2^DIGIT_W-1) of operand A, one entry per cycle. It then consumes operand B DIGIT_W bits per cycle, LSB digit first, accumulating shifted table entries. A valid/ready handshake on input and output lets it sit in the 32b multiplier datapath as a low-area alternative to the unrolled tree.

Parameters:
A_W, 32, width of multiplicand A (unsigned)
B_W, 32, width of multiplier B (unsigned); must be a multiple of DIGIT_W
DIGIT_W, 4, bits of B consumed per accumulate cycle; legal range 1..6; LUT depth = 2^DIGIT_W
EARLY_EXIT, 1, 1 = finish as soon as all unprocessed B digits are zero; 0 = fixed latency

Ports:
clk  input  1  clock, rising-edge
resetn  input  1  asynchronous reset, active-high (asserted = 1), despite the name
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
src_a  input  A_W  multiplicand
src_b  input  B_W  multiplier
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
result  output  A_W+B_W  product src_a*src_b, full width, no truncation
busy  output  1  high in BUILD or ACC

Behaviour:
- Reset (resetn=1, asynchronous): state=IDLE; result=0, accumulator=0, all LUT entries=0, digit index=0, build index=0; in_ready=1, out_valid=0, busy=0. Reset mid-operation aborts the operation with no output; the in-flight operands are lost.
- NDIG = B_W/DIGIT_W. LUT entries are A_W+DIGIT_W bits wide; the accumulator is A_W+B_W bits wide. No overflow is possible.
- IDLE: in_ready=1. When in_valid&in_ready, latch src_a and src_b, set LUT[0]=0, accumulator=0, build index k=1, and go to BUILD.
- BUILD: each cycle LUT[k] = LUT[k-1] + A and k increments. After the write of k = 2^DIGIT_W-1, go to ACC with digit index i=0. BUILD lasts exactly 2^DIGIT_W-1 cycles.
- ACC: each cycle accumulator += LUT[B digit i] << (i*DIGIT_W), and i increments. Go to DONE after i = NDIG-1.
- EARLY_EXIT=1: go to DONE after the current digit if B bits above digit i are all zero. B=0 therefore leaves ACC after 1 cycle.
- Latency: out_valid rises (2^DIGIT_W-1) + NDIG rising edges after the accept edge. Defaults give 15+8 = 23. With EARLY_EXIT, latency is (2^DIGIT_W-1) + (index of highest nonzero digit + 1), with a minimum of one ACC cycle.
- DONE: out_valid=1 and result holds the accumulator, stable until handshake. On out_valid&out_ready, go to IDLE; out_valid drops on the next edge. in_ready rises in that same next cycle, so there is no same-cycle result-out/operand-in overlap.
- in_valid outside IDLE is ignored. src_a and src_b may change freely after accept.
- out_ready held low keeps DONE indefinitely; result must not change.
- result is registered. It is updated only on entry to DONE and is otherwise held, including through IDLE, until the next DONE or reset.
- Elaboration must fail (e.g. generate-time error) if B_W % DIGIT_W != 0 or DIGIT_W is outside 1..6.

Test Plan:
- Defaults, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, out_ready=1 -> result=0xFFFFFFFE00000001; out_valid exactly 23 edges after accept, high 1 cycle; in_ready high again the cycle after.
- Defaults, src_a=7, src_b=3 -> result=21, out_valid after 16 edges (15 BUILD + 1 ACC); with EARLY_EXIT=0 -> result=21 after 23 edges.
- src_a=0x12345678, src_b=0 -> result=0 after 16 edges; src_a=0, src_b=0x80000000 -> result=0 after 23 edges.
- DIGIT_W=1, src_a=0x0000FFFF, src_b=0x00010001, EARLY_EXIT=0 -> result=0x00000000FFFFFFFF after 33 edges; DIGIT_W=2 same operands -> same result after 19 edges.
- out_ready held 0 for 10 cycles in DONE with in_valid=1 and new operands applied -> result and out_valid stable, in_ready=0, new operands ignored; then out_ready=1 -> IDLE, next accept proceeds normally.
- resetn pulsed at ACC cycle 3 -> all outputs 0, in_ready=1 asynchronously, no out_valid pulse; next operation (src_a=100, src_b=200) -> result=20000.
